frame_ram_arb: RTL and testbench

- Controller and arbiter in front of the dual-port, non-resettable frame RAM (registered read, synchronous write) in the VGA path.
- Shares the single RAM write port between two writers (A: pixel writer, B: host/pattern source) and a built-in clear engine.
- Sequences the scan-out read port: issues the address to the RAM and returns data tagged with a valid flag.
- Flags out-of-range addresses, since the RAM has no bounds checking.

---
 rtl/frame_ram_arb.sv | 135 +++++++++++++
 tb/tb_frame_ram_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_ram_arb.sv
// Write-port arbiter, clear engine and scan-out read sequencer in front of the frame RAM.
// Writers A/B share the RAM write port round-robin; the clear engine pre-empts both.
module frame_ram_arb #(
  parameter int unsigned DW    = 64,
  parameter int unsigned WORDS = 48,
  localparam int unsigned ADDRW = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [ADDRW-1:0] a_addr_i,
  input  logic [DW-1:0]    a_data_i,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  input  logic [ADDRW-1:0] b_addr_i,
  input  logic [DW-1:0]    b_data_i,
  input  logic             clr_start_i,
  input  logic [DW-1:0]    clr_value_i,
  output logic             clr_busy_o,
  output logic             clr_done_o,
  input  logic             rd_req_i,
  input  logic [ADDRW-1:0] rd_addr_i,
  output logic             rd_valid_o,
  output logic [DW-1:0]    rd_data_o,
  output logic [ADDRW-1:0] ram_rd_addr_o,
  input  logic [DW-1:0]    ram_rd_data_i,
  output logic             ram_wr_en_o,
  output logic [ADDRW-1:0] ram_wr_addr_o,
  output logic [DW-1:0]    ram_wr_data_o,
  output logic             oob_err_o
);

  localparam logic [ADDRW-1:0] LastAddr = ADDRW'(WORDS - 1);
  localparam logic [ADDRW:0]   WordsW   = (ADDRW + 1)'(WORDS);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           r_state;
  logic [ADDRW-1:0] r_cnt;
  logic [DW-1:0]    r_clr_val;
  logic             r_busy;
  logic             r_done;
  logic             r_last_a;  // 1: A won the previous grant, so B wins the next tie
  logic             r_wr_en;
  logic [ADDRW-1:0] r_wr_addr;
  logic [DW-1:0]    r_wr_data;
  logic             r_rd_valid;
  logic             r_rd_oob;
  logic             r_oob;

  logic             w_idle;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_wr_req;
  logic [ADDRW-1:0] w_wr_addr;
  logic [DW-1:0]    w_wr_data;
  logic             w_wr_oob;
  logic             w_rd_oob;

  always_comb begin
    w_idle    = (r_state == StIdle);
    w_grant_a = w_idle & a_valid_i & (~b_valid_i | ~r_last_a);
    w_grant_b = w_idle & b_valid_i & (~a_valid_i | r_last_a);
    w_wr_req  = w_grant_a | w_grant_b;
    w_wr_addr = w_grant_a ? a_addr_i : b_addr_i;
    w_wr_data = w_grant_a ? a_data_i : b_data_i;
    w_wr_oob  = w_wr_req & ({1'b0, w_wr_addr} >= WordsW);
    w_rd_oob  = rd_req_i & ({1'b0, rd_addr_i} >= WordsW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_clr_val  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_last_a   <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_oob   <= 1'b0;
      r_oob      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= rd_req_i;
      r_rd_oob   <= w_rd_oob;
      r_oob      <= w_wr_oob | w_rd_oob;
      if (w_wr_req) r_last_a <= w_grant_a;
      unique case (r_state)
        StIdle: begin
          // Out-of-range beats are consumed but never reach the RAM
          r_wr_en <= w_wr_req & ~w_wr_oob;
          if (w_wr_req && !w_wr_oob) begin
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
          end
          if (clr_start_i) begin
            r_clr_val <= clr_value_i;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= StClear;
          end
        end
        StClear: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_cnt;
          r_wr_data <= r_clr_val;
          r_cnt     <= r_cnt + ADDRW'(1);
          if (r_cnt == LastAddr) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign a_ready_o     = w_grant_a;
  assign b_ready_o     = w_grant_b;
  assign clr_busy_o    = r_busy;
  assign clr_done_o    = r_done;
  assign ram_rd_addr_o = rd_addr_i;
  assign rd_valid_o    = r_rd_valid;
  assign rd_data_o     = (r_rd_valid && !r_rd_oob) ? ram_rd_data_i : '0;
  assign ram_wr_en_o   = r_wr_en;
  assign ram_wr_addr_o = r_wr_addr;
  assign ram_wr_data_o = r_wr_data;
  assign oob_err_o     = r_oob;

endmodule

// File: tb/tb_frame_ram_arb.sv
// Directed bench for frame_ram_arb with a behavioural registered-read frame RAM model.
module tb_frame_ram_arb;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 6;
  localparam logic [DW-1:0] CV  = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] CV2 = 64'h5A5A_0000_FFFF_A5A5;

  logic          clk, rst_n;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0] a_addr, b_addr, rd_addr, ram_rd_addr, ram_wr_addr;
  logic [DW-1:0] a_data, b_data, clr_value, rd_data, ram_rd_data, ram_wr_data;
  logic          clr_start, clr_busy, clr_done, rd_req, rd_valid, ram_wr_en, oob_err;

  logic [DW-1:0] mem [64];
  int n_pass = 0;
  int n_total = 0;

  frame_ram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_addr_i(a_addr), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_addr_i(b_addr), .b_data_i(b_data),
    .clr_start_i(clr_start), .clr_value_i(clr_value), .clr_busy_o(clr_busy),
    .clr_done_o(clr_done), .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_valid_o(rd_valid),
    .rd_data_o(rd_data), .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data),
    .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data),
    .oob_err_o(oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  typedef struct {
    logic a_v; logic [AW-1:0] a_a; logic [DW-1:0] a_d;
    logic b_v; logic [AW-1:0] b_a; logic [DW-1:0] b_d;
    logic rq;  logic [AW-1:0] ra;
    logic e_ar; logic e_br; logic e_we; logic [AW-1:0] e_wa; logic [DW-1:0] e_wd;
    logic e_rv; logic [DW-1:0] e_rd; logic e_oob;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(
    input logic a_v, input logic [AW-1:0] a_a, input logic [DW-1:0] a_d,
    input logic b_v, input logic [AW-1:0] b_a, input logic [DW-1:0] b_d,
    input logic rq, input logic [AW-1:0] ra,
    input logic e_ar, input logic e_br, input logic e_we, input logic [AW-1:0] e_wa,
    input logic [DW-1:0] e_wd, input logic e_rv, input logic [DW-1:0] e_rd, input logic e_oob);
    vec_t v;
    v.a_v = a_v; v.a_a = a_a; v.a_d = a_d; v.b_v = b_v; v.b_a = b_a; v.b_d = b_d;
    v.rq = rq; v.ra = ra; v.e_ar = e_ar; v.e_br = e_br; v.e_we = e_we; v.e_wa = e_wa;
    v.e_wd = e_wd; v.e_rv = e_rv; v.e_rd = e_rd; v.e_oob = e_oob;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; rd_req = 0; clr_start = 0;
  endtask

  int dones;

  initial begin
    rst_n = 0; a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    rd_addr = '0; clr_value = '0;
    idle_inputs();

    //        A: v addr data            B: v addr data       rd        ar br we wa wd              rv rd              oob
    vecs[0]  = mkv(1, 1, 64'h11,        1, 2, 64'h22,        0, 0,     1, 0, 1, 1, 64'h11,         0, 0,              0);
    vecs[1]  = mkv(1, 1, 64'h11,        1, 2, 64'h22,        0, 0,     0, 1, 1, 2, 64'h22,         0, 0,              0);
    vecs[2]  = mkv(1, 1, 64'h11,        1, 2, 64'h22,        0, 0,     1, 0, 1, 1, 64'h11,         0, 0,              0);
    vecs[3]  = mkv(1, 1, 64'h11,        1, 2, 64'h22,        0, 0,     0, 1, 1, 2, 64'h22,         0, 0,              0);
    vecs[4]  = mkv(1, 5, 64'hDEADBEEF,  0, 0, 0,             0, 0,     1, 0, 1, 5, 64'hDEADBEEF,   0, 0,              0);
    vecs[5]  = mkv(0, 0, 0,             0, 0, 0,             0, 0,     0, 0, 0, 5, 64'hDEADBEEF,   0, 0,              0);
    vecs[6]  = mkv(0, 0, 0,             0, 0, 0,             1, 5,     0, 0, 0, 5, 64'hDEADBEEF,   1, 64'hDEADBEEF,   0);
    vecs[7]  = mkv(0, 0, 0,             1, 1, 64'h33,        0, 0,     0, 1, 1, 1, 64'h33,         0, 0,              0);
    vecs[8]  = mkv(0, 0, 0,             0, 0, 0,             1, 1,     0, 0, 0, 1, 64'h33,         1, 64'h11,         0);
    vecs[9]  = mkv(0, 0, 0,             0, 0, 0,             1, 1,     0, 0, 0, 1, 64'h33,         1, 64'h33,         0);
    vecs[10] = mkv(0, 0, 0,             1, 50, 64'h55,       0, 0,     0, 1, 0, 1, 64'h33,         0, 0,              1);
    vecs[11] = mkv(0, 0, 0,             0, 0, 0,             1, 63,    0, 0, 0, 1, 64'h33,         1, 0,              1);
    vecs[12] = mkv(1, 60, 64'h66,       0, 0, 0,             1, 62,    1, 0, 0, 1, 64'h33,         1, 0,              1);
    vecs[13] = mkv(0, 0, 0,             0, 0, 0,             0, 0,     0, 0, 0, 1, 64'h33,         0, 0,              0);
    vecs[14] = mkv(1, 4, 64'h44,        1, 3, 64'h77,        0, 0,     0, 1, 1, 3, 64'h77,         0, 0,              0);
    vecs[15] = mkv(0, 0, 0,             0, 0, 0,             1, 2,     0, 0, 0, 3, 64'h77,         1, 64'h22,         0);

    // Reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk); #1;
    chk("rst a_ready", a_ready, 0);     chk("rst b_ready", b_ready, 0);
    chk("rst busy", clr_busy, 0);       chk("rst done", clr_done, 0);
    chk("rst rd_valid", rd_valid, 0);   chk("rst rd_data", rd_data, 0);
    chk("rst wr_en", ram_wr_en, 0);     chk("rst wr_addr", ram_wr_addr, 0);
    chk("rst wr_data", ram_wr_data, 0); chk("rst oob", oob_err, 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a_valid = vecs[i].a_v; a_addr = vecs[i].a_a; a_data = vecs[i].a_d;
      b_valid = vecs[i].b_v; b_addr = vecs[i].b_a; b_data = vecs[i].b_d;
      rd_req = vecs[i].rq; rd_addr = vecs[i].ra;
      #1;
      chk($sformatf("v%0d a_ready", i), a_ready, vecs[i].e_ar);
      chk($sformatf("v%0d b_ready", i), b_ready, vecs[i].e_br);
      @(posedge clk); #1;
      chk($sformatf("v%0d wr_en", i), ram_wr_en, vecs[i].e_we);
      chk($sformatf("v%0d wr_addr", i), ram_wr_addr, vecs[i].e_wa);
      chk($sformatf("v%0d wr_data", i), ram_wr_data, vecs[i].e_wd);
      chk($sformatf("v%0d rd_valid", i), rd_valid, vecs[i].e_rv);
      chk($sformatf("v%0d rd_data", i), rd_data, vecs[i].e_rd);
      chk($sformatf("v%0d oob", i), oob_err, vecs[i].e_oob);
    end
    @(negedge clk);
    idle_inputs();

    // Full clear while A keeps requesting; start cycle still grants A
    @(negedge clk);
    a_valid = 1; a_addr = 7; a_data = 64'hAA; clr_start = 1; clr_value = CV;
    #1;
    chk("clr start a_ready", a_ready, 1);
    chk("clr start busy", clr_busy, 0);
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      clr_start = (c == 10);
      clr_value = (c == 10) ? CV2 : CV;
      #1;
      chk($sformatf("clr%0d a_ready", c), a_ready, 0);
      chk($sformatf("clr%0d busy", c), clr_busy, 1);
      chk($sformatf("clr%0d done", c), clr_done, 0);
      chk($sformatf("clr%0d wr_en", c), ram_wr_en, 1);
      chk($sformatf("clr%0d wr_addr", c), ram_wr_addr, (c == 0) ? 6'd7 : 6'(c - 1));
      chk($sformatf("clr%0d wr_data", c), ram_wr_data, (c == 0) ? 64'hAA : CV);
    end
    @(negedge clk);
    clr_start = 0; clr_value = CV;
    #1;
    chk("clr end done", clr_done, 1);
    chk("clr end busy", clr_busy, 0);
    chk("clr end wr_addr", ram_wr_addr, 47);
    chk("clr end wr_data", ram_wr_data, CV);
    chk("clr end a_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 0;
    #1;
    chk("post clr done", clr_done, 0);
    chk("post clr wr_en", ram_wr_en, 1);
    chk("post clr wr_addr", ram_wr_addr, 7);
    chk("post clr wr_data", ram_wr_data, 64'hAA);

    // Stream all words back, one per cycle
    for (int i = 0; i <= 48; i++) begin
      @(negedge clk);
      rd_req = (i < 48); rd_addr = 6'(i % 48);
      #1;
      if (i > 0) begin
        chk($sformatf("rb%0d valid", i - 1), rd_valid, 1);
        chk($sformatf("rb%0d data", i - 1), rd_data, (i - 1 == 7) ? 64'hAA : CV);
      end
    end
    @(negedge clk);
    rd_req = 0;

    // Reset in the middle of a clear
    @(negedge clk);
    clr_start = 1; clr_value = CV2;
    @(negedge clk);
    clr_start = 0;
    repeat (20) @(negedge clk);
    #1;
    chk("mid busy before rst", clr_busy, 1);
    chk("mid wr_addr before rst", ram_wr_addr, 19);
    rst_n = 0;
    #1;
    chk("mid rst busy", clr_busy, 0);
    chk("mid rst wr_en", ram_wr_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (clr_done) dones++;
    end
    chk("mid no done pulse", dones, 0);
    chk("mid busy after", clr_busy, 0);
    @(negedge clk);
    a_valid = 1; a_addr = 9; a_data = 64'h99;
    #1;
    chk("mid a_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 0;
    #1;
    chk("mid wr_en", ram_wr_en, 1);
    chk("mid wr_addr", ram_wr_addr, 9);
    chk("mid wr_data", ram_wr_data, 64'h99);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
